sgd_mem_rd_sched: RTL

Read-command scheduler between the two training-data fetch paths (A: dataset, B: labels/model) and the single shared memory read-command port. It accepts one `axis_mem_cmd`-style request per requester and splits each request into chunks that never cross a `CHUNK_BYTES` boundary. It interleaves chunks from the two requesters round-robin and pushes one tag per issued chunk (`MEM_RD_A_TAG` = 8'h0a or `MEM_RD_B_TAG` = 8'h0b) into a tag FIFO. The downstream read-data demux uses the tags to route returning data in issue order.

---
 rtl/sgd_mem_rd_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sgd_mem_rd_sched.sv
// rtl/sgd_mem_rd_sched.sv - two-requester read-command chunker/arbiter with issue-order tag FIFO
//
// Splits one pending read request per requester (A = dataset, B = labels/model)
// into chunks that never cross a CHUNK_BYTES boundary. Chunks from the two
// requesters are interleaved round-robin onto the shared memory command port.
// Every issued chunk pushes the requester's tag into a FWFT tag FIFO, which the
// read-data demux consumes to route returning data in issue order.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   s_cmd_{a,b}_valid/ready            request handshake per requester
//   s_cmd_{a,b}_address/length         64-bit byte address, 32-bit byte length
//   m_cmd_valid/ready                  chunk command handshake to memory
//   m_cmd_address/length               chunk address / length
//   m_tag_valid/ready, m_tag_data      tag FIFO head (first-word-fall-through)
//   chunks_a, chunks_b                 issued-chunk counters (wrap mod 2^32)
//   busy                               any pending work, slot or tag outstanding

module sgd_mem_rd_sched #(
  parameter int unsigned CHUNK_BYTES    = 4096,
  parameter int unsigned TAG_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_cmd_a_valid,
  output logic        s_cmd_a_ready,
  input  logic [63:0] s_cmd_a_address,
  input  logic [31:0] s_cmd_a_length,
  input  logic        s_cmd_b_valid,
  output logic        s_cmd_b_ready,
  input  logic [63:0] s_cmd_b_address,
  input  logic [31:0] s_cmd_b_length,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [63:0] m_cmd_address,
  output logic [31:0] m_cmd_length,
  output logic        m_tag_valid,
  input  logic        m_tag_ready,
  output logic [7:0]  m_tag_data,
  output logic [31:0] chunks_a,
  output logic [31:0] chunks_b,
  output logic        busy
);

  localparam int unsigned OFFW = $clog2(CHUNK_BYTES);
  localparam int unsigned PTRW = (TAG_FIFO_DEPTH > 1) ? $clog2(TAG_FIFO_DEPTH) : 1;
  localparam logic [32:0] CHUNK33   = 33'(CHUNK_BYTES);
  localparam logic [PTRW:0] DEPTH_CNT = (PTRW + 1)'(TAG_FIFO_DEPTH);
  localparam logic [7:0] MEM_RD_A_TAG = 8'h0a;
  localparam logic [7:0] MEM_RD_B_TAG = 8'h0b;
  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  // Bytes up to the next chunk boundary, capped by what is left of the request.
  // Room is at most CHUNK_BYTES, so 33 bits covers both operands without overflow.
  function automatic logic [32:0] chunk_len(input logic [63:0] addr, input logic [31:0] rem);
    logic [32:0] room;
    room = CHUNK33 - {{(33 - OFFW){1'b0}}, addr[OFFW-1:0]};
    return ({1'b0, rem} < room) ? {1'b0, rem} : room;
  endfunction

  logic            pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [63:0]     addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [31:0]     rem_a_q, rem_a_d, rem_b_q, rem_b_d;
  logic            last_grant_q, last_grant_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [63:0]     cmd_addr_q, cmd_addr_d;
  logic [31:0]     cmd_len_q, cmd_len_d;
  logic [31:0]     chunks_a_q, chunks_a_d, chunks_b_q, chunks_b_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic [7:0]      tag_mem_q [TAG_FIFO_DEPTH];

  logic        tag_full, tag_empty, slot_load, grant_a, grant_b;
  logic        push, pop;
  logic [7:0]  push_tag;
  logic [32:0] clen_a, clen_b;

  assign tag_full  = (count_q == DEPTH_CNT);
  assign tag_empty = (count_q == '0);
  assign pop       = !tag_empty && m_tag_ready;
  assign slot_load = (!cmd_valid_q || m_cmd_ready) && !tag_full;
  assign clen_a    = chunk_len(addr_a_q, rem_a_q);
  assign clen_b    = chunk_len(addr_b_q, rem_b_q);

  // Round-robin: on a tie, the port that did not win last time goes next.
  assign grant_a = slot_load && pend_a_q && (!pend_b_q || last_grant_q == LG_B);
  assign grant_b = slot_load && pend_b_q && !grant_a;

  always_comb begin
    pend_a_d     = pend_a_q;
    addr_a_d     = addr_a_q;
    rem_a_d      = rem_a_q;
    pend_b_d     = pend_b_q;
    addr_b_d     = addr_b_q;
    rem_b_d      = rem_b_q;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    chunks_a_d   = chunks_a_q;
    chunks_b_d   = chunks_b_q;
    push         = 1'b0;
    push_tag     = 8'h00;

    // Acceptance only happens while the port is idle, so it never collides
    // with a grant to the same port. Zero-length requests leave pend_v clear.
    if (s_cmd_a_valid && !pend_a_q) begin
      addr_a_d = s_cmd_a_address;
      rem_a_d  = s_cmd_a_length;
      pend_a_d = (s_cmd_a_length != 32'd0);
    end
    if (s_cmd_b_valid && !pend_b_q) begin
      addr_b_d = s_cmd_b_address;
      rem_b_d  = s_cmd_b_length;
      pend_b_d = (s_cmd_b_length != 32'd0);
    end

    if (grant_a) begin
      cmd_valid_d  = 1'b1;
      cmd_addr_d   = addr_a_q;
      cmd_len_d    = clen_a[31:0];
      push         = 1'b1;
      push_tag     = MEM_RD_A_TAG;
      addr_a_d     = addr_a_q + 64'(clen_a);
      rem_a_d      = rem_a_q - clen_a[31:0];
      pend_a_d     = (rem_a_q != clen_a[31:0]);
      chunks_a_d   = chunks_a_q + 32'd1;
      last_grant_d = LG_A;
    end else if (grant_b) begin
      cmd_valid_d  = 1'b1;
      cmd_addr_d   = addr_b_q;
      cmd_len_d    = clen_b[31:0];
      push         = 1'b1;
      push_tag     = MEM_RD_B_TAG;
      addr_b_d     = addr_b_q + 64'(clen_b);
      rem_b_d      = rem_b_q - clen_b[31:0];
      pend_b_d     = (rem_b_q != clen_b[31:0]);
      chunks_b_d   = chunks_b_q + 32'd1;
      last_grant_d = LG_B;
    end else if (m_cmd_ready) begin
      // Covers both "nothing to issue" and "tag FIFO full": a consumed slot
      // must not be presented twice.
      cmd_valid_d = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a_q     <= 1'b0;
      addr_a_q     <= '0;
      rem_a_q      <= '0;
      pend_b_q     <= 1'b0;
      addr_b_q     <= '0;
      rem_b_q      <= '0;
      last_grant_q <= LG_B;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      chunks_a_q   <= '0;
      chunks_b_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pend_a_q     <= pend_a_d;
      addr_a_q     <= addr_a_d;
      rem_a_q      <= rem_a_d;
      pend_b_q     <= pend_b_d;
      addr_b_q     <= addr_b_d;
      rem_b_q      <= rem_b_d;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      chunks_a_q   <= chunks_a_d;
      chunks_b_q   <= chunks_b_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= push_tag;
  end

  assign s_cmd_a_ready = !pend_a_q;
  assign s_cmd_b_ready = !pend_b_q;
  assign m_cmd_valid   = cmd_valid_q;
  assign m_cmd_address = cmd_addr_q;
  assign m_cmd_length  = cmd_len_q;
  assign m_tag_valid   = !tag_empty;
  assign m_tag_data    = tag_empty ? 8'h00 : tag_mem_q[rd_ptr_q];
  assign chunks_a      = chunks_a_q;
  assign chunks_b      = chunks_b_q;
  assign busy          = pend_a_q || pend_b_q || cmd_valid_q || !tag_empty;

endmodule
